// File: rtl/logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter
//
// Round-robin arbiter and sequencer in front of one shared bitwise logic unit
// (AND, OR, NOT, NAND, NOR, XOR, XNOR). One transaction is in flight at a time.
// A request is accepted in IDLE. The gate result is registered with the
// requester index, and the response is held in RESP until the consumer takes it.
//
// Optional feature macro: LOGIC_UNIT_ARB_ERR_EN
//   defined   : opcode 7 returns rsp_data=0 and rsp_err=1
//   undefined : opcode 7 passes operand A through and rsp_err is tied low
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [N_REQ]        per-requester request valid
//   req_ready  [N_REQ]        per-requester accept (one-hot or zero)
//   req_op     [3*N_REQ]      opcode, requester i at [3i +: 3]
//   req_a      [WIDTH*N_REQ]  operand A, requester i at [WIDTH*i +: WIDTH]
//   req_b      [WIDTH*N_REQ]  operand B, same packing
//   rsp_valid                 response valid
//   rsp_ready                 response consumer accept
//   rsp_id     [clog2(N_REQ)] index of the served requester
//   rsp_data   [WIDTH]        gate result
//   rsp_err                   illegal-opcode flag
//   busy                      high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module logic_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [3*N_REQ-1:0]       req_op,
    input  logic [WIDTH*N_REQ-1:0]   req_a,
    input  logic [WIDTH*N_REQ-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_nxt;

    logic            win_found;
    logic [ID_W-1:0] win_idx;
    logic            accept;

    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] sel_result;

    // Index base+offs modulo N_REQ; offs never exceeds N_REQ-1, so one
    // conditional subtraction is enough, also for non-power-of-two N_REQ.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                                 input int              offs);
        int s;
        s = int'(base) + offs;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return ID_W'(s);
    endfunction

    // Shared bitwise logic unit. Opcode 7 is the only reserved code.
    function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0]       op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = ~a;
            3'd3:    r = ~(a & b);
            3'd4:    r = ~(a | b);
            3'd5:    r = a ^ b;
            3'd6:    r = ~(a ^ b);
`ifdef LOGIC_UNIT_ARB_ERR_EN
            default: r = '0;
`else
            default: r = a;
`endif
        endcase
        return r;
    endfunction

    // Round-robin search: the first valid requester starting at ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && req_valid[rr_index(ptr, k)]) begin
                win_found = 1'b1;
                win_idx   = rr_index(ptr, k);
            end
        end
    end

    assign accept = (state == IDLE) && win_found;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = accept && (win_idx == ID_W'(i));
        end
    end

    // The winner's fields are muxed out of the packed request buses.
    assign sel_op     = req_op[3*win_idx +: 3];
    assign sel_a      = req_a[WIDTH*win_idx +: WIDTH];
    assign sel_b      = req_b[WIDTH*win_idx +: WIDTH];
    assign sel_result = gate_eval(sel_op, sel_a, sel_b);

    assign ptr_nxt = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Accept stage: the result is captured in the same cycle as the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ptr      <= ptr_nxt;
                rsp_id   <= win_idx;
                rsp_data <= sel_result;
            end
        end
    end

`ifdef LOGIC_UNIT_ARB_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (accept) begin
            rsp_err <= (sel_op == 3'd7);
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    // Response stage: outputs come only from registers and state, so nothing
    // on req_* reaches rsp_* combinationally.
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int ID_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [3*N-1:0]   req_op;
    logic [W*N-1:0]   req_a;
    logic [W*N-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [ID_W-1:0]  rsp_id;
    logic [W-1:0]     rsp_data;
    logic             rsp_err;
    logic             busy;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    typedef struct {
        int          id;
        logic [W-1:0] data;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Truth table per opcode, indexed by {a_bit, b_bit}.
    logic [3:0] tt [8];
    bit         err_en;

    initial begin
        tt[0] = 4'b1000;  // AND
        tt[1] = 4'b1110;  // OR
        tt[2] = 4'b0011;  // NOT a
        tt[3] = 4'b0111;  // NAND
        tt[4] = 4'b0001;  // NOR
        tt[5] = 4'b0110;  // XOR
        tt[6] = 4'b1001;  // XNOR
`ifdef LOGIC_UNIT_ARB_ERR_EN
        err_en = 1'b1;
        tt[7]  = 4'b0000;
`else
        err_en = 1'b0;
        tt[7]  = 4'b1100;  // pass a
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t predict(input int i);
        exp_t         e;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        op     = req_op[3*i +: 3];
        a      = req_a[W*i +: W];
        b      = req_b[W*i +: W];
        e.id   = i;
        e.err  = err_en && (op == 3'd7);
        e.data = '0;
        for (int k = 0; k < W; k++) e.data[k] = tt[op][{a[k], b[k]}];
        return e;
    endfunction

    // Reference model: decides grants from the spec's round-robin rule and
    // pushes the expected response for each accepted request.
    int m_ptr  = 0;
    bit m_resp = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            m_ptr  = 0;
            m_resp = 0;
            check("reset_rsp_valid", {31'b0, rsp_valid}, 0);
            check("reset_busy",      {31'b0, busy}, 0);
            check("reset_rsp_id",    {30'b0, rsp_id}, 0);
            check("reset_rsp_data",  {24'b0, rsp_data}, 0);
            check("reset_rsp_err",   {31'b0, rsp_err}, 0);
        end else if (!m_resp) begin
            int           win;
            logic [N-1:0] exp_rdy;
            win     = -1;
            exp_rdy = '0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (win < 0 && req_valid[c]) win = c;
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            check("req_ready_idle", {28'b0, req_ready}, {28'b0, exp_rdy});
            check("busy_idle",      {31'b0, busy}, 0);
            check("rsp_valid_idle", {31'b0, rsp_valid}, 0);
            if (win >= 0) begin
                sbq.push_back(predict(win));
                m_ptr  = (win + 1) % N;
                m_resp = 1;
            end
        end else begin
            check("req_ready_resp", {28'b0, req_ready}, 0);
            check("busy_resp",      {31'b0, busy}, 1);
            check("rsp_valid_resp", {31'b0, rsp_valid}, 1);
            if (rsp_ready) m_resp = 0;
        end
    end

    // Monitor: compares every presented response against the queue head;
    // repeated comparison while stalled also covers output stability.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sbq.size() == 0) begin
                check("rsp_without_request", {31'b0, rsp_valid}, 0);
            end else begin
                check("rsp_id",   {30'b0, rsp_id}, sbq[0].id);
                check("rsp_data", {24'b0, rsp_data}, {24'b0, sbq[0].data});
                check("rsp_err",  {31'b0, rsp_err}, {31'b0, sbq[0].err});
                if (rsp_ready) void'(sbq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        req_op[3*i +: 3] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [N-1:0] acc;
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single request from requester 2: XOR F0,3C
        set_req(2, 3'd5, 8'hF0, 8'h3C);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        tick();

        // Every opcode from requester 0
        for (int op = 0; op < 8; op++) begin
            set_req(0, 3'(op), 8'hA5, 8'h0F);
            req_valid = 4'b0001;
            tick();
            req_valid = '0;
            tick();
        end
        set_req(0, 3'd7, 8'h3C, 8'h00);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        tick();

        // Fairness: all requesters held valid, from ptr=0
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 3'(i + 1), W'($urandom), W'($urandom));
        req_valid = 4'b1111;
        repeat (12) tick();
        req_valid = '0;
        tick();
        tick();

        // Backpressure for 5 cycles with other requesters waiting
        rsp_ready = 1'b0;
        set_req(1, 3'd3, 8'h5A, 8'hF3);
        req_valid = 4'b0010;
        tick();
        set_req(0, 3'd1, 8'h11, 8'h22);
        set_req(2, 3'd4, 8'h33, 8'h44);
        set_req(3, 3'd6, 8'h55, 8'h66);
        req_valid = 4'b1101;
        repeat (5) tick();
        rsp_ready = 1'b1;
        repeat (6) tick();
        req_valid = '0;
        repeat (3) tick();

        // Reset while a response is pending
        rsp_ready = 1'b0;
        set_req(3, 3'd1, 8'h81, 8'h18);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_rsp_valid", {31'b0, rsp_valid}, 0);
        check("async_reset_busy",      {31'b0, busy}, 0);
        tick();
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        set_req(1, 3'd0, 8'hFF, 8'h0F);
        set_req(3, 3'd5, 8'hAA, 8'hFF);
        req_valid = 4'b1010;
        tick();
        req_valid = 4'b1000;
        tick();
        tick();
        req_valid = '0;
        repeat (3) tick();

        // Randomized traffic with random backpressure and request withdrawal
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            acc = req_ready & req_valid;
            @(posedge clk);
            #1;
            rsp_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !acc[i]) begin
                    if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    set_req(i, 3'($urandom_range(7)), W'($urandom), W'($urandom));
                    req_valid[i] = 1'b1;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end

        // Drain with a bounded wait
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (sbq.size() == 0 && !busy) break;
            tick();
        end
        check("drain_queue_empty", sbq.size(), 0);
        check("drain_busy",        {31'b0, busy}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
